// File: rtl/cc40_cmd_scheduler.sv
// CC-40 command scheduler: arms on a qualifying asynchronous parameter write, waits a
// whole number of seconds, then pulses req and loads alternating command frames A/B.
module cc40_cmd_scheduler #(
    parameter int unsigned CLK_PER_SEC = 80000000,
    parameter int unsigned PERIOD_SEC  = 120,
    parameter int unsigned REQ_LEN     = 20,
    parameter logic [10:0] TRIG_ADDR   = 11'd511,
    parameter logic [11:0] DATA_MAX    = 12'd60,
    parameter int unsigned NUM_BYTES   = 4,
    parameter logic [8*NUM_BYTES-1:0] CMD_A = {8'd3, 8'd0, 8'd21, 8'd50},
    parameter logic [8*NUM_BYTES-1:0] CMD_B = {8'd46, 8'd0, 8'd22, 8'd50},
    parameter bit          PERIODIC    = 1'b0,
    parameter bit          ONE_SHOT    = 1'b1,
    localparam int unsigned IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          WE,
    input  logic [10:0]   sAddr,
    input  logic [11:0]   sData,
    input  logic          cancel,
    input  logic [IW-1:0] numBytes,
    output logic          req,
    output logic          ena,
    output logic          sign,
    output logic [7:0]    fireCnt,
    output logic [7:0]    oData,
    output logic [1:0]    dbg_state
);

    localparam int unsigned TW = $clog2(CLK_PER_SEC);
    localparam int unsigned SW = (PERIOD_SEC > 1) ? $clog2(PERIOD_SEC) : 1;
    localparam int unsigned RW = $clog2(REQ_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_CNT   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             we_sync_q;
    logic                   we_rise;
    logic [TW-1:0]          tick_q, tick_d;
    logic [SW-1:0]          sec_q, sec_d;
    logic                   fire;
    logic [RW-1:0]          req_cnt_q;
    logic                   sign_q;
    logic                   fired_q;
    logic [7:0]             fire_cnt_q;
    logic [8*NUM_BYTES-1:0] mem_q;
    logic [7:0]             odata_q, odata_d;

    // sAddr/sData are stable while WE is high, so they are safe to read in CHECK.
    assign we_rise = ~we_sync_q[2] & we_sync_q[1];

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        sec_d   = sec_q;
        fire    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (we_rise && !(ONE_SHOT && fired_q)) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (sAddr == TRIG_ADDR && sData < DATA_MAX) begin
                    state_d = ST_CNT;
                    tick_d  = '0;
                    sec_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CNT: begin
                // cancel takes priority over a fire landing in the same cycle
                if (cancel) begin
                    state_d = ST_IDLE;
                    tick_d  = '0;
                    sec_d   = '0;
                end else if (tick_q == TW'(CLK_PER_SEC - 1)) begin
                    tick_d = '0;
                    if (sec_q == SW'(PERIOD_SEC - 1)) begin
                        fire    = 1'b1;
                        sec_d   = '0;
                        state_d = PERIODIC ? ST_CNT : ST_IDLE;
                    end else begin
                        sec_d = sec_q + 1'b1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        odata_d = '0;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (numBytes == IW'(k)) odata_d = mem_q[8*k +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            we_sync_q  <= '0;
            tick_q     <= '0;
            sec_q      <= '0;
            req_cnt_q  <= '0;
            sign_q     <= 1'b0;
            fired_q    <= 1'b0;
            fire_cnt_q <= '0;
            mem_q      <= '0;
            odata_q    <= '0;
        end else begin
            state_q   <= state_d;
            we_sync_q <= {we_sync_q[1:0], WE};
            tick_q    <= tick_d;
            sec_q     <= sec_d;
            odata_q   <= odata_d;
            if (fire) begin
                // sign_q is the pre-toggle value: 0 means this fire is an A fire
                sign_q     <= ~sign_q;
                fire_cnt_q <= fire_cnt_q + 8'd1;
                fired_q    <= 1'b1;
                req_cnt_q  <= RW'(REQ_LEN);
                mem_q      <= sign_q ? CMD_B : CMD_A;
            end else if (req_cnt_q != '0) begin
                req_cnt_q <= req_cnt_q - 1'b1;
            end
        end
    end

    assign req       = (req_cnt_q != '0);
    assign ena       = (state_q == ST_CNT);
    assign sign      = sign_q;
    assign fireCnt   = fire_cnt_q;
    assign oData     = odata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_cc40_cmd_scheduler.sv
// Bench for cc40_cmd_scheduler: four instances (one-shot, re-triggerable, periodic,
// 3-byte frame) share stimulus; an event-time reference model predicts their outputs.
module tb_cc40_cmd_scheduler;

    localparam int NI = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       WE = 1'b0;
    logic       cancel = 1'b0;
    logic [10:0] sAddr = '0;
    logic [11:0] sData = '0;
    logic [1:0] numBytes = '0;

    logic       req_w [NI];
    logic       ena_w [NI];
    logic       sign_w [NI];
    logic [7:0] fcnt_w [NI];
    logic [7:0] od_w [NI];
    logic [1:0] dbg_w [NI];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cc40_cmd_scheduler #(.CLK_PER_SEC(10), .PERIOD_SEC(3), .REQ_LEN(4),
        .PERIODIC(1'b0), .ONE_SHOT(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .WE(WE), .sAddr(sAddr), .sData(sData), .cancel(cancel),
        .numBytes(numBytes), .req(req_w[0]), .ena(ena_w[0]), .sign(sign_w[0]),
        .fireCnt(fcnt_w[0]), .oData(od_w[0]), .dbg_state(dbg_w[0]));

    cc40_cmd_scheduler #(.CLK_PER_SEC(10), .PERIOD_SEC(3), .REQ_LEN(4),
        .PERIODIC(1'b0), .ONE_SHOT(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .WE(WE), .sAddr(sAddr), .sData(sData), .cancel(cancel),
        .numBytes(numBytes), .req(req_w[1]), .ena(ena_w[1]), .sign(sign_w[1]),
        .fireCnt(fcnt_w[1]), .oData(od_w[1]), .dbg_state(dbg_w[1]));

    cc40_cmd_scheduler #(.CLK_PER_SEC(10), .PERIOD_SEC(3), .REQ_LEN(4),
        .PERIODIC(1'b1), .ONE_SHOT(1'b0)) u_dut2 (
        .clk(clk), .rst(rst), .WE(WE), .sAddr(sAddr), .sData(sData), .cancel(cancel),
        .numBytes(numBytes), .req(req_w[2]), .ena(ena_w[2]), .sign(sign_w[2]),
        .fireCnt(fcnt_w[2]), .oData(od_w[2]), .dbg_state(dbg_w[2]));

    cc40_cmd_scheduler #(.CLK_PER_SEC(10), .PERIOD_SEC(3), .REQ_LEN(4), .NUM_BYTES(3),
        .CMD_A({8'd3, 8'd21, 8'd50}), .CMD_B({8'd46, 8'd22, 8'd50}),
        .PERIODIC(1'b0), .ONE_SHOT(1'b1)) u_dut3 (
        .clk(clk), .rst(rst), .WE(WE), .sAddr(sAddr), .sData(sData), .cancel(cancel),
        .numBytes(numBytes), .req(req_w[3]), .ena(ena_w[3]), .sign(sign_w[3]),
        .fireCnt(fcnt_w[3]), .oData(od_w[3]), .dbg_state(dbg_w[3]));

    // ---------------- reference model (event times in clock edges) ----------------
    int          os_p [NI] = '{1, 0, 0, 1};
    int          per_p [NI] = '{0, 0, 1, 0};
    int          nb_p [NI] = '{4, 4, 4, 3};
    logic [7:0]  cmd_a [NI][4] = '{'{50, 21, 0, 3}, '{50, 21, 0, 3}, '{50, 21, 0, 3}, '{50, 21, 3, 0}};
    logic [7:0]  cmd_b [NI][4] = '{'{50, 22, 0, 46}, '{50, 22, 0, 46}, '{50, 22, 0, 46}, '{50, 22, 46, 0}};

    int unsigned edge_n = 0;
    int          m_mode [NI];          // 0 idle, 1 checking, 2 counting
    int unsigned fire_at [NI];
    int unsigned req_end [NI];
    bit          m_fired [NI];
    bit          m_sign [NI];
    logic [7:0]  m_fcnt [NI];
    logic [7:0]  m_od [NI];
    logic [7:0]  m_mem [NI][4];
    bit          we_last;
    bit          rise_pend;
    int unsigned rise_eval;

    always @(posedge clk) begin
        edge_n++;
        if (!rst) begin
            we_last   = 1'b0;
            rise_pend = 1'b0;
            for (int i = 0; i < NI; i++) begin
                m_mode[i] = 0; m_fired[i] = 0; m_sign[i] = 0; m_fcnt[i] = 0; m_od[i] = 0;
                req_end[i] = 0; fire_at[i] = 0;
                for (int b = 0; b < 4; b++) m_mem[i][b] = 0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                m_od[i] = (int'(numBytes) < nb_p[i]) ? m_mem[i][numBytes] : 8'd0;
                if (m_mode[i] == 2) begin
                    if (cancel) m_mode[i] = 0;
                    else if (edge_n == fire_at[i]) begin
                        m_sign[i]  = ~m_sign[i];
                        m_fcnt[i]  = m_fcnt[i] + 8'd1;
                        m_fired[i] = 1;
                        req_end[i] = edge_n + 4;
                        for (int b = 0; b < 4; b++) m_mem[i][b] = m_sign[i] ? cmd_a[i][b] : cmd_b[i][b];
                        if (per_p[i] != 0) fire_at[i] = edge_n + 30;
                        else m_mode[i] = 0;
                    end
                end else if (m_mode[i] == 1) begin
                    if (sAddr == 11'd511 && sData < 12'd60) begin
                        m_mode[i]  = 2;
                        fire_at[i] = edge_n + 30;
                    end else m_mode[i] = 0;
                end else if (rise_pend && rise_eval == edge_n && !(os_p[i] != 0 && m_fired[i])) begin
                    m_mode[i] = 1;
                end
            end
            if (rise_pend && rise_eval == edge_n) rise_pend = 1'b0;
            // a write rise seen at edge m is acted on by an idle scheduler at edge m+2
            if (WE && !we_last) begin
                rise_pend = 1'b1;
                rise_eval = edge_n + 2;
            end
            we_last = WE;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; WE = 1'b0; cancel = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if ({req_w[i], ena_w[i], sign_w[i], fcnt_w[i], od_w[i]} !== 19'd0) begin
                n_err++;
                $display("FAIL reset dut%0d: got req=%b ena=%b sign=%b cnt=%0d od=%0d, need all 0",
                         i, req_w[i], ena_w[i], sign_w[i], fcnt_w[i], od_w[i]);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_single_fire();
        int ena_first = -1, ena_cnt = 0, req_first = -1, req_cnt = 0;
        logic [7:0] exp_a [4];
        exp_a = '{8'd50, 8'd21, 8'd0, 8'd3};
        sAddr = 11'd511; sData = 12'd5; WE = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (c == 4) WE = 1'b0;
            if (ena_w[0]) begin if (ena_first < 0) ena_first = c; ena_cnt++; end
            if (req_w[0]) begin if (req_first < 0) req_first = c; req_cnt++; end
        end
        n_vec++; if (ena_first != 3) begin n_err++; $display("FAIL fire1_ena_start: got %0d need 3", ena_first); end
        n_vec++; if (ena_cnt != 30) begin n_err++; $display("FAIL fire1_ena_len: got %0d need 30", ena_cnt); end
        n_vec++; if (req_first != 33) begin n_err++; $display("FAIL fire1_req_start: got %0d need 33", req_first); end
        n_vec++; if (req_cnt != 4) begin n_err++; $display("FAIL fire1_req_len: got %0d need 4", req_cnt); end
        for (int k = 0; k < 4; k++) begin
            numBytes = 2'(k);
            @(negedge clk);
            n_vec++;
            if (od_w[0] !== exp_a[k]) begin
                n_err++; $display("FAIL fire1_byte%0d: got %0d need %0d", k, od_w[0], exp_a[k]);
            end
        end
        n_vec++; if (sign_w[0] !== 1'b1) begin n_err++; $display("FAIL fire1_sign: got %b need 1", sign_w[0]); end
        n_vec++; if (fcnt_w[0] !== 8'd1) begin n_err++; $display("FAIL fire1_cnt: got %0d need 1", fcnt_w[0]); end
    endtask

    task automatic test_second_fire();
        int ena0 = 0, req0 = 0, ena1_first = -1, req1 = 0;
        logic [7:0] exp_a [4];
        logic [7:0] exp_b [4];
        exp_a = '{8'd50, 8'd21, 8'd0, 8'd3};
        exp_b = '{8'd50, 8'd22, 8'd0, 8'd46};
        sAddr = 11'd511; sData = 12'd7; WE = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (c == 4) WE = 1'b0;
            if (ena_w[0]) ena0++;
            if (req_w[0]) req0++;
            if (ena_w[1] && ena1_first < 0) ena1_first = c;
            if (req_w[1]) req1++;
        end
        n_vec++; if (ena0 != 0 || req0 != 0) begin n_err++; $display("FAIL oneshot_ignore: got ena=%0d req=%0d need 0 0", ena0, req0); end
        n_vec++; if (ena1_first != 3) begin n_err++; $display("FAIL fire2_ena_start: got %0d need 3", ena1_first); end
        n_vec++; if (req1 != 4) begin n_err++; $display("FAIL fire2_req_len: got %0d need 4", req1); end
        for (int k = 0; k < 4; k++) begin
            numBytes = 2'(k);
            @(negedge clk);
            n_vec++;
            if (od_w[1] !== exp_b[k]) begin n_err++; $display("FAIL fire2_byte%0d: got %0d need %0d", k, od_w[1], exp_b[k]); end
            n_vec++;
            if (od_w[0] !== exp_a[k]) begin n_err++; $display("FAIL oneshot_byte%0d: got %0d need %0d", k, od_w[0], exp_a[k]); end
        end
        n_vec++; if (sign_w[1] !== 1'b0) begin n_err++; $display("FAIL fire2_sign: got %b need 0", sign_w[1]); end
        n_vec++; if (fcnt_w[1] !== 8'd2) begin n_err++; $display("FAIL fire2_cnt: got %0d need 2", fcnt_w[1]); end
        n_vec++; if (fcnt_w[0] !== 8'd1) begin n_err++; $display("FAIL oneshot_cnt: got %0d need 1", fcnt_w[0]); end
    endtask

    task automatic test_invalid();
        logic [10:0] addrs [3];
        logic [11:0] datas [3];
        int          armed [3];
        addrs = '{11'd510, 11'd511, 11'd511};
        datas = '{12'd5, 12'd60, 12'd59};
        armed = '{0, 0, 1};
        do_reset();
        for (int t = 0; t < 3; t++) begin
            int ena_first = -1, req_cnt = 0;
            sAddr = addrs[t]; sData = datas[t]; WE = 1'b1;
            for (int c = 0; c < 45; c++) begin
                @(negedge clk);
                if (c == 4) WE = 1'b0;
                if (ena_w[1] && ena_first < 0) ena_first = c;
                if (req_w[1]) req_cnt++;
            end
            n_vec++;
            if (ena_first != (armed[t] != 0 ? 3 : -1) || req_cnt != (armed[t] != 0 ? 4 : 0)) begin
                n_err++;
                $display("FAIL trig_qual addr=%0d data=%0d: got ena_start=%0d req=%0d, need armed=%0d",
                         addrs[t], datas[t], ena_first, req_cnt, armed[t]);
            end
        end
    endtask

    task automatic test_cancel();
        int ena_cnt = 0, req_cnt = 0;
        logic ena_after = 1'b1;
        do_reset();
        sAddr = 11'd511; sData = 12'd5; WE = 1'b1;
        for (int c = 0; c < 130; c++) begin
            @(negedge clk);
            if (c == 4) WE = 1'b0;
            if (c == 19) ena_after = ena_w[0];
            if (ena_w[0]) ena_cnt++;
            for (int i = 0; i < NI; i++) if (req_w[i]) req_cnt++;
            cancel = (c == 18);
        end
        n_vec++; if (ena_cnt != 16) begin n_err++; $display("FAIL cancel_ena_len: got %0d need 16", ena_cnt); end
        n_vec++; if (ena_after !== 1'b0) begin n_err++; $display("FAIL cancel_ena_drop: got %b need 0", ena_after); end
        n_vec++; if (req_cnt != 0) begin n_err++; $display("FAIL cancel_no_req: got %0d req cycles need 0", req_cnt); end
        for (int k = 0; k < 4; k++) begin
            numBytes = 2'(k);
            @(negedge clk);
            n_vec++;
            if (od_w[0] !== 8'd0) begin n_err++; $display("FAIL cancel_mem%0d: got %0d need 0", k, od_w[0]); end
        end
    endtask

    task automatic test_periodic();
        int   k = 0;
        int   od_chk_at = -1;
        logic [7:0] od_exp = '0;
        logic prev = 1'b0;
        do_reset();
        sAddr = 11'd511; sData = 12'd5; numBytes = 2'd3; WE = 1'b1;
        for (int c = 0; c < 8000 && k < 258; c++) begin
            @(negedge clk);
            if (c == 4 || c == 45 || c == 105) WE = 1'b0;
            if (c == 40 || c == 100) WE = 1'b1;
            if (c == od_chk_at) begin
                n_vec++;
                if (od_w[2] !== od_exp) begin n_err++; $display("FAIL periodic_frame fire%0d: got %0d need %0d", k, od_w[2], od_exp); end
            end
            if (req_w[2] && !prev) begin
                k++;
                n_vec++;
                if (c != 33 + 30 * (k - 1)) begin n_err++; $display("FAIL periodic_time fire%0d: got %0d need %0d", k, c, 33 + 30 * (k - 1)); end
                n_vec++;
                if (sign_w[2] !== ((k % 2) == 1)) begin n_err++; $display("FAIL periodic_sign fire%0d: got %b", k, sign_w[2]); end
                n_vec++;
                if (fcnt_w[2] !== 8'(k)) begin n_err++; $display("FAIL periodic_cnt fire%0d: got %0d need %0d", k, fcnt_w[2], 8'(k)); end
                od_chk_at = c + 2;
                od_exp = ((k % 2) == 1) ? 8'd3 : 8'd46;
            end
            prev = req_w[2];
        end
        n_vec++;
        if (k != 258) begin n_err++; $display("FAIL periodic_timeout: got %0d fires need 258", k); end
    endtask

    task automatic test_reset_mid();
        int ena_first = -1;
        logic pre_req;
        logic [7:0] pre_od;
        do_reset();
        sAddr = 11'd511; sData = 12'd5; numBytes = 2'd0; WE = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            if (c == 4) WE = 1'b0;
        end
        rst = 1'b0; #1;
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if (ena_w[i] !== 1'b0 || req_w[i] !== 1'b0) begin n_err++; $display("FAIL rst_mid_cnt dut%0d: got ena=%b req=%b need 0 0", i, ena_w[i], req_w[i]); end
        end
        @(negedge clk); rst = 1'b1;
        WE = 1'b1;
        for (int c = 0; c <= 34; c++) begin
            @(negedge clk);
            if (c == 4) WE = 1'b0;
        end
        pre_req = req_w[0]; pre_od = od_w[0];
        n_vec++;
        if (pre_req !== 1'b1 || pre_od !== 8'd50) begin n_err++; $display("FAIL rst_mid_pre: got req=%b od=%0d need 1 50", pre_req, pre_od); end
        rst = 1'b0; #1;
        n_vec++;
        if ({req_w[0], ena_w[0], sign_w[0], fcnt_w[0], od_w[0]} !== 19'd0) begin
            n_err++; $display("FAIL rst_mid_req: got req=%b ena=%b sign=%b cnt=%0d od=%0d need all 0",
                              req_w[0], ena_w[0], sign_w[0], fcnt_w[0], od_w[0]);
        end
        @(negedge clk); rst = 1'b1;
        WE = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 4) WE = 1'b0;
            if (ena_w[0] && ena_first < 0) ena_first = c;
        end
        n_vec++;
        if (ena_first != 3) begin n_err++; $display("FAIL oneshot_rearm: got %0d need 3", ena_first); end
    endtask

    task automatic test_random();
        int we_hold = 0, gap = 0;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                n_vec++;
                if (req_w[i] !== (edge_n < req_end[i])) begin n_err++; $display("FAIL rnd_req dut%0d cyc%0d: got %b need %b", i, c, req_w[i], edge_n < req_end[i]); end
                n_vec++;
                if (ena_w[i] !== (m_mode[i] == 2)) begin n_err++; $display("FAIL rnd_ena dut%0d cyc%0d: got %b need %b", i, c, ena_w[i], m_mode[i] == 2); end
                n_vec++;
                if (sign_w[i] !== m_sign[i]) begin n_err++; $display("FAIL rnd_sign dut%0d cyc%0d: got %b need %b", i, c, sign_w[i], m_sign[i]); end
                n_vec++;
                if (fcnt_w[i] !== m_fcnt[i]) begin n_err++; $display("FAIL rnd_cnt dut%0d cyc%0d: got %0d need %0d", i, c, fcnt_w[i], m_fcnt[i]); end
                n_vec++;
                if (od_w[i] !== m_od[i]) begin n_err++; $display("FAIL rnd_od dut%0d cyc%0d: got %0d need %0d", i, c, od_w[i], m_od[i]); end
            end
            if (we_hold > 0) begin
                we_hold--;
                if (we_hold == 0) begin WE = 1'b0; gap = int'($urandom_range(3, 9)); end
            end else if (gap > 0) begin
                gap--;
            end else if ($urandom_range(0, 9) == 0) begin
                sAddr = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 2047)) : 11'd511;
                sData = 12'($urandom_range(0, 70));
                WE = 1'b1;
                we_hold = int'($urandom_range(4, 7));
            end
            cancel = ($urandom_range(0, 59) == 0);
            numBytes = 2'($urandom_range(0, 3));
        end
        cancel = 1'b0; WE = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_fire();
        test_second_fire();
        test_invalid();
        test_cancel();
        test_periodic();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
